// File: rtl/video_timing_pkg.sv
// ----------------------------------------------------------------------------
// video_timing_pkg
// Shared constants and types for the pixel-FIFO display path.
//   * Default 640x480 raster timing (active / front porch / sync / back porch).
//   * PIXEL_W, IMG_W, IMG_H: pixel width and size of the image the producer
//     writes into the FIFO (one frame = IMG_W*IMG_H words).
//   * rgb_t: one 24-bit RGB pixel.
//   * cnt_width(): width of a counter that must hold 0..n-1.
// No ports (package).
// ----------------------------------------------------------------------------
package video_timing_pkg;

    // Horizontal timing, in pixel clocks
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;

    // Vertical timing, in lines
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    // Pixel format and image geometry
    localparam int PIXEL_W  = 24;
    localparam int IMG_W    = 80;
    localparam int IMG_H    = 60;

    typedef logic [PIXEL_W-1:0] rgb_t;

    localparam rgb_t BG_COLOR = 24'h000000;

    // Width of the optional missed-pixel counter
    localparam int UF_CNT_W = 16;

    // Bits needed for a counter running 0..n-1 (at least one bit)
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_display_reader_if.sv
// ----------------------------------------------------------------------------
// fifo_display_reader_if
// Bundles the FIFO read port and the video output of fifo_display_reader.
//   fifo_data     FIFO read data, valid one cycle after read_fifo
//   empty_fifo    FIFO empty flag
//   read_fifo     FIFO read enable
//   rgb           pixel colour
//   hsync, vsync  active-low syncs
//   de            data enable (active area)
//   sof           one-cycle pulse with the first active pixel of a frame
//   underflow     sticky underflow flag
//   underflow_cnt missed-pixel count (only when UNDERFLOW_CNT_EN is defined)
// Modports: master = the reader block, slave = FIFO + video sink side.
// Optional feature macro: UNDERFLOW_CNT_EN.
// ----------------------------------------------------------------------------
interface fifo_display_reader_if;
    import video_timing_pkg::*;

    rgb_t        fifo_data;
    logic        empty_fifo;
    logic        read_fifo;
    rgb_t        rgb;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic        sof;
    logic        underflow;
`ifdef UNDERFLOW_CNT_EN
    logic [UF_CNT_W-1:0] underflow_cnt;
`endif

`ifdef UNDERFLOW_CNT_EN
    modport master (
        input  fifo_data, empty_fifo,
        output read_fifo, rgb, hsync, vsync, de, sof, underflow, underflow_cnt
    );
    modport slave (
        output fifo_data, empty_fifo,
        input  read_fifo, rgb, hsync, vsync, de, sof, underflow, underflow_cnt
    );
`else
    modport master (
        input  fifo_data, empty_fifo,
        output read_fifo, rgb, hsync, vsync, de, sof, underflow
    );
    modport slave (
        output fifo_data, empty_fifo,
        input  read_fifo, rgb, hsync, vsync, de, sof, underflow
    );
`endif

endinterface

// File: rtl/raster_timing_gen.sv
// ----------------------------------------------------------------------------
// raster_timing_gen
// Horizontal/vertical raster counters and region decode.
// Ports:
//   clk          pixel clock
//   rst          asynchronous reset, active-low
//   window_now   current counter position lies in the image window (comb)
//   first_now    current counter position is (0,0) (comb)
//   hsync, vsync registered active-low syncs (latency 1 from the counters)
//   de           registered active-area flag
//   sof          registered pulse for position (0,0)
// The combinational window/first outputs let the parent issue the FIFO read
// in the same cycle as the counter, so the returned word lines up with the
// registered timing outputs one cycle later.
// ----------------------------------------------------------------------------
module raster_timing_gen #(
    parameter int H_ACTIVE = video_timing_pkg::H_ACTIVE,
    parameter int H_FP     = video_timing_pkg::H_FP,
    parameter int H_SYNC   = video_timing_pkg::H_SYNC,
    parameter int H_BP     = video_timing_pkg::H_BP,
    parameter int V_ACTIVE = video_timing_pkg::V_ACTIVE,
    parameter int V_FP     = video_timing_pkg::V_FP,
    parameter int V_SYNC   = video_timing_pkg::V_SYNC,
    parameter int V_BP     = video_timing_pkg::V_BP,
    parameter int IMG_W    = video_timing_pkg::IMG_W,
    parameter int IMG_H    = video_timing_pkg::IMG_H
) (
    input  logic clk,
    input  logic rst,
    output logic window_now,
    output logic first_now,
    output logic hsync,
    output logic vsync,
    output logic de,
    output logic sof
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = video_timing_pkg::cnt_width(H_TOTAL);
    localparam int V_W     = video_timing_pkg::cnt_width(V_TOTAL);

    typedef logic [H_W-1:0] h_cnt_t;
    typedef logic [V_W-1:0] v_cnt_t;

    localparam h_cnt_t H_LAST      = h_cnt_t'(H_TOTAL - 1);
    localparam h_cnt_t H_ACT_END   = h_cnt_t'(H_ACTIVE);
    localparam h_cnt_t H_WIN_END   = h_cnt_t'(IMG_W);
    localparam h_cnt_t H_SYNC_BEG  = h_cnt_t'(H_ACTIVE + H_FP);
    localparam h_cnt_t H_SYNC_END  = h_cnt_t'(H_ACTIVE + H_FP + H_SYNC);

    localparam v_cnt_t V_LAST      = v_cnt_t'(V_TOTAL - 1);
    localparam v_cnt_t V_ACT_END   = v_cnt_t'(V_ACTIVE);
    localparam v_cnt_t V_WIN_END   = v_cnt_t'(IMG_H);
    localparam v_cnt_t V_SYNC_BEG  = v_cnt_t'(V_ACTIVE + V_FP);
    localparam v_cnt_t V_SYNC_END  = v_cnt_t'(V_ACTIVE + V_FP + V_SYNC);

    h_cnt_t h_cnt_reg, h_cnt_next;
    v_cnt_t v_cnt_reg, v_cnt_next;

    logic   h_end;
    logic   v_end;
    logic   active_now;
    logic   hsync_now;
    logic   vsync_now;

    logic   hsync_reg;
    logic   vsync_reg;
    logic   de_reg;
    logic   sof_reg;

    // ---------------- counters ----------------
    assign h_end = (h_cnt_reg == H_LAST);
    assign v_end = (v_cnt_reg == V_LAST);

    always_comb begin
        h_cnt_next = h_end ? '0 : h_cnt_reg + h_cnt_t'(1);
        v_cnt_next = v_cnt_reg;
        if (h_end) begin
            v_cnt_next = v_end ? '0 : v_cnt_reg + v_cnt_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else begin
            h_cnt_reg <= h_cnt_next;
            v_cnt_reg <= v_cnt_next;
        end
    end

    // ---------------- region decode (current counter) ----------------
    assign active_now = (h_cnt_reg < H_ACT_END) && (v_cnt_reg < V_ACT_END);
    assign window_now = (h_cnt_reg < H_WIN_END) && (v_cnt_reg < V_WIN_END);
    assign first_now  = (h_cnt_reg == '0) && (v_cnt_reg == '0);
    assign hsync_now  = !((h_cnt_reg >= H_SYNC_BEG) && (h_cnt_reg < H_SYNC_END));
    assign vsync_now  = !((v_cnt_reg >= V_SYNC_BEG) && (v_cnt_reg < V_SYNC_END));

    // ---------------- registered timing outputs ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hsync_reg <= 1'b1;
            vsync_reg <= 1'b1;
            de_reg    <= 1'b0;
            sof_reg   <= 1'b0;
        end else begin
            hsync_reg <= hsync_now;
            vsync_reg <= vsync_now;
            de_reg    <= active_now;
            sof_reg   <= first_now;
        end
    end

    assign hsync = hsync_reg;
    assign vsync = vsync_reg;
    assign de    = de_reg;
    assign sof   = sof_reg;

endmodule

// File: rtl/fifo_display_reader.sv
// ----------------------------------------------------------------------------
// fifo_display_reader
// Consumer end of the image pixel FIFO. Generates raster timing and shows the
// FIFO image in the top-left IMG_W x IMG_H window; the rest of the active area
// shows BG_COLOR and blanking shows black.
// Ports:
//   clk   pixel clock
//   rst   asynchronous reset, active-low
//   bus   fifo_display_reader_if.master (FIFO read port + video output)
// Timing: every video output reflects the raster position of the previous
// cycle. The FIFO read is issued combinationally for the current position and
// its data (valid one cycle later) is muxed straight onto rgb, so rgb lines up
// with hsync/vsync/de/sof.
// A window pixel that finds the FIFO empty is dropped (shown as BG_COLOR) and
// sets the sticky underflow flag; there is no catch-up read.
// Optional feature macro: UNDERFLOW_CNT_EN adds bus.underflow_cnt, a
// saturating count of dropped window pixels cleared only by reset.
// ----------------------------------------------------------------------------
module fifo_display_reader #(
    parameter int H_ACTIVE = video_timing_pkg::H_ACTIVE,
    parameter int H_FP     = video_timing_pkg::H_FP,
    parameter int H_SYNC   = video_timing_pkg::H_SYNC,
    parameter int H_BP     = video_timing_pkg::H_BP,
    parameter int V_ACTIVE = video_timing_pkg::V_ACTIVE,
    parameter int V_FP     = video_timing_pkg::V_FP,
    parameter int V_SYNC   = video_timing_pkg::V_SYNC,
    parameter int V_BP     = video_timing_pkg::V_BP,
    parameter int IMG_W    = video_timing_pkg::IMG_W,
    parameter int IMG_H    = video_timing_pkg::IMG_H,
    parameter video_timing_pkg::rgb_t BG_COLOR = video_timing_pkg::BG_COLOR
) (
    input  logic                        clk,
    input  logic                        rst,
    fifo_display_reader_if.master       bus
);

    logic window_now;
    logic first_now;
    logic de_out;
    logic rd_en;
    logic uf_event;

    logic pix_ok_reg;
    logic underflow_reg, underflow_next;

    raster_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .IMG_W    (IMG_W),
        .IMG_H    (IMG_H)
    ) u_timing (
        .clk        (clk),
        .rst        (rst),
        .window_now (window_now),
        .first_now  (first_now),
        .hsync      (bus.hsync),
        .vsync      (bus.vsync),
        .de         (de_out),
        .sof        (bus.sof)
    );

    assign bus.de = de_out;

    // Counters sit at (0,0) during reset, which is inside the window, so the
    // read enable is qualified with rst to keep it low while reset is held.
    assign rd_en    = rst && window_now && !bus.empty_fifo;
    assign uf_event = window_now && bus.empty_fifo;

    assign bus.read_fifo = rd_en;

    // Sticky flag restarts each frame at (0,0); a miss on that very pixel
    // must still leave the flag set.
    always_comb begin
        underflow_next = underflow_reg | uf_event;
        if (first_now) begin
            underflow_next = uf_event;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_ok_reg    <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            pix_ok_reg    <= rd_en;
            underflow_reg <= underflow_next;
        end
    end

    assign bus.underflow = underflow_reg;

    // fifo_data is the FIFO's own registered output, so selecting it here
    // keeps rgb on the same cycle as the registered timing outputs.
    always_comb begin
        if (pix_ok_reg) begin
            bus.rgb = bus.fifo_data;
        end else if (de_out) begin
            bus.rgb = BG_COLOR;
        end else begin
            bus.rgb = '0;
        end
    end

`ifdef UNDERFLOW_CNT_EN
    localparam int CW = video_timing_pkg::UF_CNT_W;

    logic [CW-1:0] uf_cnt_reg, uf_cnt_next;

    always_comb begin
        uf_cnt_next = uf_cnt_reg;
        if (uf_event && (uf_cnt_reg != {CW{1'b1}})) begin
            uf_cnt_next = uf_cnt_reg + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            uf_cnt_reg <= '0;
        end else begin
            uf_cnt_reg <= uf_cnt_next;
        end
    end

    assign bus.underflow_cnt = uf_cnt_reg;
`endif

endmodule

// File: tb/tb_fifo_display_reader.sv
// ----------------------------------------------------------------------------
// tb_fifo_display_reader
// Self-checking bench for fifo_display_reader using a reduced raster so whole
// frames run quickly. The reference model derives the raster position from
// the cycle count since reset and keeps the FIFO as a queue.
// ----------------------------------------------------------------------------
module tb_fifo_display_reader;
    import video_timing_pkg::*;

    localparam int HA = 16, HFP = 2, HS = 3, HBP = 3;
    localparam int VA = 12, VFP = 2, VS = 2, VBP = 2;
    localparam int IW = 6,  IH = 4;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;
    localparam int IMG_PIX = IW * IH;
    localparam rgb_t BG = 24'h123456;

    logic clk;
    logic rst;

    fifo_display_reader_if vif ();

    fifo_display_reader #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
        .IMG_W    (IW), .IMG_H (IH), .BG_COLOR (BG)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (vif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   vectors = 0;
    int   errors  = 0;
    int   k;              // clock edges since reset release
    bit   uf_m;           // model sticky underflow
    int   ucnt_m;         // model missed-pixel count
    rgb_t fifo_q[$];
    int   rd_cnt, hs_lo, vs_lo, de_hi, sof_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            if (errors <= 20)
                $display("FAIL %s: got=%0h expected=%0h (edge %0d)", tag, got, exp, k);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, ".read_fifo"}, 32'(vif.read_fifo), 32'd0);
        check_eq({tag, ".rgb"},       32'(vif.rgb),       32'd0);
        check_eq({tag, ".hsync"},     32'(vif.hsync),     32'd1);
        check_eq({tag, ".vsync"},     32'(vif.vsync),     32'd1);
        check_eq({tag, ".de"},        32'(vif.de),        32'd0);
        check_eq({tag, ".sof"},       32'(vif.sof),       32'd0);
        check_eq({tag, ".underflow"}, 32'(vif.underflow), 32'd0);
    endtask

    task automatic clear_stats();
        rd_cnt = 0; hs_lo = 0; vs_lo = 0; de_hi = 0; sof_cnt = 0;
    endtask

    // One pixel clock. Entered at a negedge (or shortly after reset release),
    // returns at the following negedge with outputs checked.
    task automatic step(input bit idx_mode, input int push_pct);
        int   pos, hx, vy;
        bit   win, act, exp_rd, ev, rd_seen;
        bit   exp_hs, exp_vs, exp_sof;
        rgb_t word, exp_rgb;

        pos = k % FRAME;
        hx  = pos % HT;
        vy  = pos / HT;
        win = (hx < IW) && (vy < IH);
        act = (hx < HA) && (vy < VA);
        exp_rd = win && (fifo_q.size() != 0);
        ev     = win && (fifo_q.size() == 0);
        word   = '0;
        if (exp_rd) word = idx_mode ? rgb_t'(vy * IW + hx) : fifo_q[0];

        rd_seen = vif.read_fifo;
        check_eq("read_fifo", 32'(rd_seen), 32'(exp_rd));
        if (rd_seen) rd_cnt++;

        @(posedge clk);
        #1;
        if (rd_seen && fifo_q.size() != 0) vif.fifo_data = fifo_q.pop_front();
        if ($urandom_range(99) < push_pct) fifo_q.push_back(rgb_t'($urandom()));
        vif.empty_fifo = (fifo_q.size() == 0);

        exp_hs  = !((hx >= HA + HFP) && (hx < HA + HFP + HS));
        exp_vs  = !((vy >= VA + VFP) && (vy < VA + VFP + VS));
        exp_sof = (pos == 0);
        exp_rgb = exp_rd ? word : (act ? BG : rgb_t'(0));
        uf_m    = exp_sof ? ev : (uf_m | ev);
        if (ev && ucnt_m < 65535) ucnt_m++;
        k++;

        @(negedge clk);
        check_eq("rgb",       32'(vif.rgb),       32'(exp_rgb));
        check_eq("hsync",     32'(vif.hsync),     32'(exp_hs));
        check_eq("vsync",     32'(vif.vsync),     32'(exp_vs));
        check_eq("de",        32'(vif.de),        32'(act));
        check_eq("sof",       32'(vif.sof),       32'(exp_sof));
        check_eq("underflow", 32'(vif.underflow), 32'(uf_m));
`ifdef UNDERFLOW_CNT_EN
        check_eq("underflow_cnt", 32'(vif.underflow_cnt), 32'(ucnt_m));
`endif
        if (!vif.hsync) hs_lo++;
        if (!vif.vsync) vs_lo++;
        if (vif.de)     de_hi++;
        if (vif.sof)    sof_cnt++;
    endtask

    task automatic preload(input int n, input bit incrementing);
        for (int i = 0; i < n; i++)
            fifo_q.push_back(incrementing ? rgb_t'(i) : rgb_t'($urandom()));
        vif.empty_fifo = (fifo_q.size() == 0);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        vif.empty_fifo = 1'b1;
        vif.fifo_data  = '0;
        k = 0; uf_m = 1'b0; ucnt_m = 0;
        clear_stats();

        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;

        // Empty FIFO for two frames: timing counts, no reads, underflow set
        repeat (2 * FRAME) step(1'b0, 0);
        check_eq("hsync_low_cycles", 32'(hs_lo),   32'(2 * HS * VT));
        check_eq("vsync_low_cycles", 32'(vs_lo),   32'(2 * VS * HT));
        check_eq("de_high_cycles",   32'(de_hi),   32'(2 * HA * VA));
        check_eq("sof_pulses",       32'(sof_cnt), 32'd2);
        check_eq("reads_when_empty", 32'(rd_cnt),  32'd0);
`ifdef UNDERFLOW_CNT_EN
        check_eq("missed_2_frames",  32'(vif.underflow_cnt), 32'(2 * IMG_PIX));
`endif

        // Full image preloaded: every window pixel read, image index on rgb
        clear_stats();
        preload(IMG_PIX, 1'b1);
        repeat (FRAME) step(1'b1, 0);
        check_eq("reads_full_frame", 32'(rd_cnt), 32'(IMG_PIX));
        check_eq("fifo_drained",     32'(fifo_q.size()), 32'd0);

        // Only 10 words: the rest of the window underflows
        clear_stats();
        preload(10, 1'b1);
        repeat (FRAME) step(1'b1, 0);
        check_eq("reads_partial", 32'(rd_cnt), 32'd10);

        // Refill before the next frame: flag clears at sof, data resumes at (0,0)
        clear_stats();
        preload(IMG_PIX, 1'b0);
        repeat (FRAME) step(1'b0, 0);
        check_eq("reads_after_refill", 32'(rd_cnt), 32'(IMG_PIX));

        // Random trickle fill
        repeat (3 * FRAME) step(1'b0, 5);

        // Advance to mid-line, then async reset between clock edges
        for (int n = 0; n < FRAME && (k % FRAME) != 3 * HT + 10; n++) step(1'b0, 5);
        check_eq("reached_mid_line", 32'(k % FRAME), 32'(3 * HT + 10));
        preload(4, 1'b0);
        #1;
        rst = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset_held");
        rst = 1'b1;
        k = 0; uf_m = 1'b0; ucnt_m = 0;
        clear_stats();
        #1;
        step(1'b0, 0);
        check_eq("sof_first_clock", 32'(sof_cnt), 32'd1);
        repeat (FRAME + HT) step(1'b0, 5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
